// File: rtl/dispatch_pkg.sv
// Shared types and constants for tile dispatch and related shared-resource blocks.
package dispatch_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic TILE_SFTM   = 1'b0;
    localparam logic TILE_DFCONV = 1'b1;

    // Up to eight cores can retire together, so an 8-bit population count suffices.
    function automatic logic [CNT_W-1:0] popcount8(input logic [7:0] v);
        popcount8 = '0;
        for (int i = 0; i < 8; i++) begin
            popcount8 = popcount8 + CNT_W'(v[i]);
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or above i_ptr (with wrap) wins a one-hot grant.
// Purely combinational; no backpressure of its own.
module rr_arbiter #(
    parameter int N   = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt
);
    logic w_found;
    int   w_idx;

    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = (int'(i_ptr) + k) % N;
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO: head data visible combinationally, push/pop same cycle allowed.
// Latency 1 cycle push-to-head; caller must not push when full nor pop when empty.
module sync_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dat,
    output logic             o_empty,
    output logic             o_full
);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FULL_CNT);
    assign o_dat   = r_mem[r_rd];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_clr) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/tile_dispatcher.sv
// Buffers a layer's tiles and issues them in order to free cores, round-robin; pulses done at layer end.
// Tile-to-issue latency 1 cycle; upstream stalls on full FIFO or quota reached, head stalls with no eligible core.
module tile_dispatcher
    import dispatch_pkg::*;
#(
    parameter int                   NUM_CORES   = 2,
    parameter int                   FIFO_DEPTH  = 4,
    parameter logic [NUM_CORES-1:0] DFCONV_MASK = {NUM_CORES{1'b1}}
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     tile_total,
    input  logic                 tile_valid,
    input  logic                 tile_is_dfconv,
    output logic                 tile_ready,
    output logic [NUM_CORES-1:0] core_issue_valid,
    output logic                 core_issue_dfconv,
    input  logic [NUM_CORES-1:0] core_issue_ready,
    input  logic [NUM_CORES-1:0] core_done,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     retired_count,
    output logic                 err_spurious
);
    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_total;
    logic [CNT_W-1:0]     r_accepted;
    logic [CNT_W-1:0]     r_retired;
    logic [NUM_CORES-1:0] r_outstanding;
    logic [PTR_W-1:0]     r_rr_ptr;
    logic [PTR_W-1:0]     w_rr_nxt;
    logic                 r_err;
    logic                 w_start_acc;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_fifo_empty;
    logic                 w_fifo_full;
    logic                 w_head;
    logic [NUM_CORES-1:0] w_req;
    logic [NUM_CORES-1:0] w_gnt;
    logic [NUM_CORES-1:0] w_ret;
    logic [NUM_CORES-1:0] w_spur;

    assign w_start_acc = start && (r_state == IDLE);
    assign tile_ready  = (r_state == RUN) && !w_fifo_full && (r_accepted < r_total);
    assign w_push      = tile_valid && tile_ready;

    sync_fifo #(.WIDTH(1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_start_acc),
        .i_push  (w_push),
        .i_dat   (tile_is_dfconv),
        .i_pop   (w_pop),
        .o_dat   (w_head),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    // An SFTM head ignores the mask; a DFConv head only sees cores allowed to run it.
    always_comb begin
        w_req = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_req[i] = (r_state == RUN) && !w_fifo_empty && !r_outstanding[i] &&
                       core_issue_ready[i] && (w_head != TILE_DFCONV || DFCONV_MASK[i]);
        end
    end

    rr_arbiter #(.N(NUM_CORES)) u_arb (
        .i_req (w_req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt)
    );

    assign w_pop             = |w_gnt;
    assign core_issue_valid  = w_gnt;
    assign core_issue_dfconv = !w_fifo_empty && w_head;
    assign w_ret             = core_done & r_outstanding;
    assign w_spur            = core_done & ~r_outstanding;
    assign retired_count     = r_retired;
    assign err_spurious      = r_err;

    always_comb begin
        w_rr_nxt = r_rr_ptr;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (w_gnt[i]) w_rr_nxt = PTR_W'((i + 1) % NUM_CORES);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: if (start) w_state_nxt = (tile_total == '0) ? DONE : RUN;
            RUN: begin
                busy = 1'b1;
                if (r_retired == r_total) w_state_nxt = DONE;
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_total       <= '0;
            r_accepted    <= '0;
            r_retired     <= '0;
            r_outstanding <= '0;
            r_rr_ptr      <= '0;
            r_err         <= 1'b0;
        end else if (w_start_acc) begin
            r_total       <= tile_total;
            r_accepted    <= '0;
            r_retired     <= '0;
            r_outstanding <= '0;
            r_rr_ptr      <= '0;
            r_err         <= 1'b0;
        end else begin
            if (w_push) r_accepted <= r_accepted + 1'b1;
            r_retired     <= r_retired + popcount8(8'(w_ret));
            r_outstanding <= (r_outstanding & ~w_ret) | w_gnt;
            r_rr_ptr      <= w_rr_nxt;
            if (|w_spur) r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tile_dispatcher.sv
// Directed bench: stimulus queues expected grants, a negedge monitor pops and compares each issue.
module tb_tile_dispatcher;
    localparam int NC = 2;

    typedef struct packed {
        logic [2:0] core;
        logic       dfc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   tile_total = '0;
    logic          tile_valid = 1'b0;
    logic          tile_is_dfconv = 1'b0;
    logic          tile_ready;
    logic [NC-1:0] core_issue_valid;
    logic          core_issue_dfconv;
    logic [NC-1:0] core_issue_ready = '0;
    logic [NC-1:0] model_done = '0;
    logic [NC-1:0] spur_done = '0;
    logic [NC-1:0] core_done;
    logic          busy;
    logic          done;
    logic [15:0]   retired_count;
    logic          err_spurious;

    int   checks = 0;
    int   failures = 0;
    int   done_pulses = 0;
    int   cnt [NC];
    exp_t exp_q [$];

    assign core_done = model_done | spur_done;

    tile_dispatcher #(.NUM_CORES(NC), .FIFO_DEPTH(4), .DFCONV_MASK(2'b01)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .tile_total        (tile_total),
        .tile_valid        (tile_valid),
        .tile_is_dfconv    (tile_is_dfconv),
        .tile_ready        (tile_ready),
        .core_issue_valid  (core_issue_valid),
        .core_issue_dfconv (core_issue_dfconv),
        .core_issue_ready  (core_issue_ready),
        .core_done         (core_done),
        .busy              (busy),
        .done              (done),
        .retired_count     (retired_count),
        .err_spurious      (err_spurious)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_issue(input int c, input logic d);
        exp_t e;
        e.core = 3'(c);
        e.dfc  = d;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] n);
        tile_total = n;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic send_tile(input logic t, input int budget, output bit ok);
        tile_valid     = 1'b1;
        tile_is_dfconv = t;
        ok             = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            if (tile_ready) ok = 1'b1;
            tick();
        end
        tile_valid = 1'b0;
    endtask

    // Waits for the done pulse; in a RUN layer the cycle before DONE must already show the full count.
    task automatic wait_done(input logic [15:0] total, input bit from_run, input int budget);
        bit          seen;
        logic        prev_busy;
        logic [15:0] prev_ret;
        seen      = 1'b0;
        prev_busy = 1'b0;
        prev_ret  = '0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else begin
                prev_busy = busy;
                prev_ret  = retired_count;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("done_retired", 32'(retired_count), 32'(total));
            check("done_busy_low", 32'(busy), 32'd0);
            check("done_tile_ready_low", 32'(tile_ready), 32'd0);
            if (from_run) begin
                check("pre_done_retired", 32'(prev_ret), 32'(total));
                check("pre_done_busy", 32'(prev_busy), 32'd1);
            end
            @(negedge clk);
            check("done_one_cycle", 32'(done), 32'd0);
            check("idle_busy_low", 32'(busy), 32'd0);
        end
    endtask

    // Core model: each granted core pulses done three cycles after its issue edge.
    initial begin
        for (int i = 0; i < NC; i++) cnt[i] = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_done = '0;
                for (int i = 0; i < NC; i++) cnt[i] = 0;
            end else begin
                for (int i = 0; i < NC; i++) begin
                    model_done[i] = (cnt[i] == 1);
                    if (cnt[i] > 0) cnt[i]--;
                    if (core_issue_valid[i] && core_issue_ready[i]) cnt[i] = 3;
                end
            end
        end
    end

    initial begin
        exp_t          e;
        logic [NC-1:0] oh;
        forever begin
            @(negedge clk);
            if (done) done_pulses++;
            if (rst_n && core_issue_valid != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_issue", 32'(core_issue_valid), 32'd0);
                end else begin
                    e  = exp_q.pop_front();
                    oh = '0;
                    oh[e.core] = 1'b1;
                    check("issue_core", 32'(core_issue_valid), 32'(oh));
                    check("issue_type", 32'(core_issue_dfconv), 32'(e.dfc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        bit ok;
        int d0;
        logic tt [5];

        repeat (2) @(posedge clk);
        #1;
        check("rst_tile_ready", 32'(tile_ready), 32'd0);
        check("rst_issue_valid", 32'(core_issue_valid), 32'd0);
        check("rst_issue_dfconv", 32'(core_issue_dfconv), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_retired", 32'(retired_count), 32'd0);
        check("rst_err", 32'(err_spurious), 32'd0);
        rst_n = 1'b1;
        tick();

        // Four SFTM tiles alternate across both cores.
        core_issue_ready = 2'b11;
        d0 = done_pulses;
        do_start(16'd4);
        check("run_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) expect_issue(i % 2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            send_tile(1'b0, 20, ok);
            check("t1_accept", 32'(ok), 32'd1);
        end
        wait_done(16'd4, 1'b1, 40);
        check("t1_done_count", 32'(done_pulses - d0), 32'd1);
        check("t1_queue_drained", 32'(exp_q.size()), 32'd0);

        // Core1 cannot run DFConv: both D tiles serialise on core0, S then goes to core1.
        tick();
        do_start(16'd3);
        expect_issue(0, 1'b1);
        expect_issue(0, 1'b1);
        expect_issue(1, 1'b0);
        send_tile(1'b1, 20, ok);
        check("t2_accept_d0", 32'(ok), 32'd1);
        send_tile(1'b1, 20, ok);
        check("t2_accept_d1", 32'(ok), 32'd1);
        send_tile(1'b0, 20, ok);
        check("t2_accept_s", 32'(ok), 32'd1);
        wait_done(16'd3, 1'b1, 40);
        check("t2_queue_drained", 32'(exp_q.size()), 32'd0);

        // Cores stalled: FIFO fills at four, fifth tile held off until it drains.
        tick();
        core_issue_ready = 2'b00;
        tt[0] = 1'b0; tt[1] = 1'b0; tt[2] = 1'b1; tt[3] = 1'b0; tt[4] = 1'b0;
        do_start(16'd5);
        for (int i = 0; i < 4; i++) begin
            send_tile(tt[i], 4, ok);
            check("t3_accept_fill", 32'(ok), 32'd1);
        end
        send_tile(tt[4], 6, ok);
        check("t3_fifth_refused", 32'(ok), 32'd0);
        check("t3_ready_low_full", 32'(tile_ready), 32'd0);
        check("t3_no_issue", 32'(core_issue_valid), 32'd0);
        expect_issue(0, 1'b0);
        expect_issue(1, 1'b0);
        expect_issue(0, 1'b1);
        expect_issue(1, 1'b0);
        expect_issue(0, 1'b0);
        core_issue_ready = 2'b11;
        send_tile(tt[4], 20, ok);
        check("t3_fifth_accepted", 32'(ok), 32'd1);
        wait_done(16'd5, 1'b1, 60);
        check("t3_retired", 32'(retired_count), 32'd5);
        check("t3_queue_drained", 32'(exp_q.size()), 32'd0);

        // Empty layer: done on the cycle after start, no tile ever accepted.
        tick();
        check("t4_pre_ready", 32'(tile_ready), 32'd0);
        do_start(16'd0);
        check("t4_ready_low", 32'(tile_ready), 32'd0);
        wait_done(16'd0, 1'b0, 1);

        // Spurious completion on idle core1 is sticky and leaves the count alone.
        tick();
        do_start(16'd1);
        spur_done = 2'b10;
        tick();
        spur_done = 2'b00;
        check("t5_err_set", 32'(err_spurious), 32'd1);
        check("t5_retired_same", 32'(retired_count), 32'd0);
        expect_issue(0, 1'b0);
        send_tile(1'b0, 20, ok);
        check("t5_accept", 32'(ok), 32'd1);
        wait_done(16'd1, 1'b1, 40);
        check("t5_err_sticky", 32'(err_spurious), 32'd1);

        // Mid-layer reset after two retirements, then a clean two-tile layer.
        tick();
        do_start(16'd4);
        check("t6_err_cleared", 32'(err_spurious), 32'd0);
        for (int i = 0; i < 4; i++) expect_issue(i % 2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            send_tile(1'b0, 20, ok);
            check("t6_accept", 32'(ok), 32'd1);
        end
        for (int c = 0; c < 30 && retired_count != 16'd2; c++) @(negedge clk);
        check("t6_two_retired", 32'(retired_count), 32'd2);
        d0 = done_pulses;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_ready", 32'(tile_ready), 32'd0);
        check("t6_rst_issue", 32'(core_issue_valid), 32'd0);
        check("t6_rst_dfconv", 32'(core_issue_dfconv), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_done", 32'(done), 32'd0);
        check("t6_rst_retired", 32'(retired_count), 32'd0);
        check("t6_rst_err", 32'(err_spurious), 32'd0);
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("t6_no_done_after_abort", 32'(done_pulses - d0), 32'd0);
        check("t6_idle_after_reset", 32'(busy), 32'd0);
        do_start(16'd2);
        expect_issue(0, 1'b0);
        expect_issue(1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            send_tile(1'b0, 20, ok);
            check("t6_restart_accept", 32'(ok), 32'd1);
        end
        wait_done(16'd2, 1'b1, 40);
        check("t6_queue_drained", 32'(exp_q.size()), 32'd0);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
